i2c_target: RTL and testbench

I2C target (slave) controller; the receiving end of the bus whose SCL the controller side generates from the divided system clock. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address, receives write bytes and transmits read bytes through a simple byte-strobe interface to local logic. Open-drain: the block only ever pulls SDA low; the pad/tri-state lives outside.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_sync_edge.sv | 32 +++
 rtl/i2c_target.sv | 185 ++++++++++++++++++
 tb/tb_i2c_target.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus constants for the I2C target.
// Imported by i2c_target; no ports.
package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_WR_DATA   = 3'd3,
    ST_WR_ACK    = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_RD_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } i2c_tgt_state_e;

  localparam logic I2C_ACK      = 1'b0;
  localparam logic I2C_NACK     = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: SYNC_STAGES-deep synchronizer plus edge detect.
// Ports: i_clk, i_rst, i_pin (async) -> o_level, o_rise, o_fall.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Reset to 1: an idle I2C bus is pulled high.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = o_level & ~r_prev;
  assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C target with 7-bit address match and byte strobes.
// Ports: clk, rst, scl_i, sda_i, sda_oe, rx_data/rx_valid, tx_data/tx_req, busy.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_tgt_state_e r_state;
  logic [2:0]     r_bitcnt;
  logic           r_full;
  logic [7:0]     r_shift;
  logic [7:0]     r_tx_shift;
  logic           r_rw;
  logic           r_mack;
  logic           r_sda_oe;
  logic [7:0]     r_rx_data;
  logic           r_rx_valid;
  logic           r_tx_req;
  logic           r_busy;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pin  (scl_i),
    .o_level(w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_pin  (sda_i),
    .o_level(w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  // r_full marks "8 bits shifted in": the counter alone wraps to 0
  // and cannot tell a finished byte from a freshly started one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= 3'd0;
      r_full     <= 1'b0;
      r_shift    <= 8'h00;
      r_tx_shift <= 8'h00;
      r_rw       <= I2C_RW_WRITE;
      r_mack     <= I2C_NACK;
      r_sda_oe   <= 1'b0;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_tx_req   <= 1'b0;
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        // Repeated START keeps the session; a new
        // address that misses ends it below.
        r_state  <= ST_ADDR;
        r_bitcnt <= 3'd0;
        r_full   <= 1'b0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_full <= 1'b1;
            end else if (w_scl_fall && r_full) begin
              r_full <= 1'b0;
              if (r_shift[7:1] == TARGET_ADDR) begin
                r_state  <= ST_ADDR_ACK;
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_rw     <= r_shift[0];
                r_tx_req <= (r_shift[0] == I2C_RW_READ);
              end else begin
                r_state <= ST_WAIT_STOP;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bitcnt <= 3'd0;
              r_full   <= 1'b0;
              if (r_rw == I2C_RW_READ) begin
                r_state    <= ST_RD_DATA;
                r_tx_shift <= tx_data;
                r_sda_oe   <= ~tx_data[7];
              end else begin
                r_state  <= ST_WR_DATA;
                r_sda_oe <= 1'b0;
              end
            end
          end
          ST_WR_DATA: begin
            if (w_scl_rise) begin
              r_shift  <= {r_shift[6:0], w_sda};
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) r_full <= 1'b1;
            end else if (w_scl_fall && r_full) begin
              r_full     <= 1'b0;
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
              r_sda_oe   <= 1'b1;
              r_state    <= ST_WR_ACK;
            end
          end
          ST_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_oe <= 1'b0;
              r_bitcnt <= 3'd0;
              r_state  <= ST_WR_DATA;
            end
          end
          ST_RD_DATA: begin
            // Each fall ends the bit on the wire; put up the next.
            if (w_scl_fall) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_sda_oe <= 1'b0;
                r_tx_req <= 1'b1;
                r_state  <= ST_RD_ACK;
              end else begin
                r_sda_oe   <= ~r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (w_scl_rise) begin
              r_mack <= w_sda;
            end else if (w_scl_fall) begin
              r_bitcnt <= 3'd0;
              if (r_mack == I2C_ACK) begin
                r_tx_shift <= tx_data;
                r_sda_oe   <= ~tx_data[7];
                r_state    <= ST_RD_DATA;
              end else begin
                r_sda_oe <= 1'b0;
                r_state  <= ST_WAIT_STOP;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe   = r_sda_oe;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign tx_req   = r_tx_req;
  assign busy     = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-level bench for i2c_target.
// Drives SCL/SDA as the controller; SDA is a wired-AND with sda_oe.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic [7:0] tx_data;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_req;
  logic       busy;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_target #(.TARGET_ADDR(7'h42), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_bus),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int         rx_cnt;
  logic [7:0] rx_log[4];
  int         tx_cnt;
  int         oe_cnt;
  int         busy_hi;
  int         busy_lo;
  logic       mon_busy;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_cnt < 4) rx_log[rx_cnt] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_req) tx_cnt = tx_cnt + 1;
    if (sda_oe) oe_cnt = oe_cnt + 1;
    if (busy) busy_hi = busy_hi + 1;
    if (mon_busy && !busy) busy_lo = busy_lo + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon();
    rx_cnt  = 0;
    tx_cnt  = 0;
    oe_cnt  = 0;
    busy_hi = 0;
    busy_lo = 0;
  endtask

  task automatic waitq();
    repeat (Q) @(negedge clk);
  endtask

  // Works from idle and as a repeated START with SCL low.
  task automatic i2c_start();
    sda_m = 1'b1; waitq();
    scl_m = 1'b1; waitq();
    sda_m = 1'b0; waitq();
    scl_m = 1'b0; waitq();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; waitq();
    scl_m = 1'b1; waitq();
    sda_m = 1'b1; waitq();
  endtask

  task automatic bit_x(input logic b, output logic r);
    sda_m = b;    waitq();
    scl_m = 1'b1; waitq();
    r = sda_bus;  waitq();
    scl_m = 1'b0; waitq();
  endtask

  task automatic xfer8(input logic [7:0] drv, output logic [7:0] got);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_x(drv[i], r);
      got[i] = r;
    end
  endtask

  logic [7:0] got;
  logic       ack;
  int         snap;
  int         wt;

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    mon_busy = 1'b0;
    clr_mon();
    repeat (4) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'h0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_tx_req", 32'(tx_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Write 0x84, A5, 3C
    clr_mon();
    i2c_start();
    xfer8(8'h84, got); bit_x(1'b1, ack);
    chk("wr_addr_ack", 32'(ack), 32'h0);
    chk("wr_busy", 32'(busy), 32'h1);
    xfer8(8'hA5, got); bit_x(1'b1, ack);
    chk("wr_d0_ack", 32'(ack), 32'h0);
    xfer8(8'h3C, got); bit_x(1'b1, ack);
    chk("wr_d1_ack", 32'(ack), 32'h0);
    i2c_stop();
    chk("wr_rx_cnt", 32'(rx_cnt), 32'd2);
    chk("wr_rx0", 32'(rx_log[0]), 32'hA5);
    chk("wr_rx1", 32'(rx_log[1]), 32'h3C);
    chk("wr_rx_hold", 32'(rx_data), 32'h3C);
    chk("wr_busy_stop", 32'(busy), 32'h0);

    // Read 0x85: 5A (ACK), C3 (NACK)
    clr_mon();
    tx_data = 8'h5A;
    i2c_start();
    xfer8(8'h85, got); bit_x(1'b1, ack);
    chk("rd_addr_ack", 32'(ack), 32'h0);
    xfer8(8'hFF, got);
    chk("rd_byte0", 32'(got), 32'h5A);
    chk("rd_txreq_b0", 32'(tx_cnt), 32'd2);
    tx_data = 8'hC3;
    bit_x(1'b0, ack);
    xfer8(8'hFF, got);
    chk("rd_byte1", 32'(got), 32'hC3);
    chk("rd_txreq_b1", 32'(tx_cnt), 32'd3);
    snap = tx_cnt;
    bit_x(1'b1, ack);
    chk("rd_oe_nack", 32'(sda_oe), 32'h0);
    i2c_stop();
    chk("rd_txreq_after", 32'(tx_cnt), 32'(snap));
    chk("rd_rx_none", 32'(rx_cnt), 32'd0);

    // Wrong address 0x48
    clr_mon();
    i2c_start();
    xfer8(8'h90, got); bit_x(1'b1, ack);
    chk("na_addr_nack", 32'(ack), 32'h1);
    xfer8(8'hFF, got); bit_x(1'b1, ack);
    chk("na_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    chk("na_oe_cnt", 32'(oe_cnt), 32'd0);
    chk("na_rx_cnt", 32'(rx_cnt), 32'd0);
    chk("na_busy_hi", 32'(busy_hi), 32'd0);

    // Write 0x11, repeated START, read 0x80
    clr_mon();
    i2c_start();
    xfer8(8'h84, got); bit_x(1'b1, ack);
    chk("rs_addr_ack", 32'(ack), 32'h0);
    mon_busy = 1'b1;
    xfer8(8'h11, got); bit_x(1'b1, ack);
    chk("rs_wr_ack", 32'(ack), 32'h0);
    tx_data = 8'h80;
    i2c_start();
    xfer8(8'h85, got); bit_x(1'b1, ack);
    chk("rs_rd_ack", 32'(ack), 32'h0);
    xfer8(8'hFF, got);
    chk("rs_rd_byte", 32'(got), 32'h80);
    bit_x(1'b1, ack);
    mon_busy = 1'b0;
    i2c_stop();
    chk("rs_rx0", 32'(rx_log[0]), 32'h11);
    chk("rs_rx_cnt", 32'(rx_cnt), 32'd1);
    chk("rs_busy_gap", 32'(busy_lo), 32'd0);

    // STOP after 4 data bits
    clr_mon();
    i2c_start();
    xfer8(8'h84, got); bit_x(1'b1, ack);
    chk("sp_addr_ack", 32'(ack), 32'h0);
    bit_x(1'b1, ack); bit_x(1'b0, ack);
    bit_x(1'b1, ack); bit_x(1'b0, ack);
    sda_m = 1'b0; waitq();
    scl_m = 1'b1; waitq();
    sda_m = 1'b1;
    repeat (4) @(negedge clk);
    chk("sp_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("sp_oe", 32'(sda_oe), 32'h0);
    chk("sp_busy", 32'(busy), 32'h0);
    chk("sp_rx_cnt", 32'(rx_cnt), 32'd0);
    waitq();

    // Reset while ACK is driven
    i2c_start();
    xfer8(8'h84, got);
    wt = 0;
    while (!sda_oe && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    chk("rr_ack_driven", 32'(sda_oe), 32'h1);
    rst = 1'b1;
    #1;
    chk("rr_oe_async", 32'(sda_oe), 32'h0);
    chk("rr_busy_async", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) waitq();
    clr_mon();
    i2c_start();
    xfer8(8'h84, got); bit_x(1'b1, ack);
    chk("rr_addr_ack", 32'(ack), 32'h0);
    chk("rr_busy", 32'(busy), 32'h1);
    i2c_stop();
    chk("rr_busy_stop", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
